// File: rtl/bus_pkg.sv
// Shared types and constants for the fetch/execute memory bus arbiter.
package bus_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic {
        OWNER_FETCH,
        OWNER_EXECUTE
    } owner_e;

    localparam logic [3:0] WSTRB_WORD = 4'hF;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester and memory-bus signals of the arbiter, grouped by side.
// Handshake: a requester raises *_req with stable fields and holds them until a
// one-cycle *_ack or *_err; the bus m_req stays high until one-cycle m_ack/m_err.
interface bus_arbiter_if;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_ack;
    logic        f_err;
    logic [31:0] f_rdata;

    logic        e_req;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_rdata;

    logic        m_req;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_rdata;

    // The arbiter is the bus master.
    modport master (
        input  f_req, f_addr, e_req, e_addr, e_we, e_wdata, e_wstrb,
        input  m_ack, m_err, m_rdata,
        output f_ack, f_err, f_rdata, e_ack, e_err, e_rdata,
        output m_req, m_addr, m_we, m_wdata, m_wstrb
    );

    modport slave (
        output f_req, f_addr, e_req, e_addr, e_we, e_wdata, e_wstrb,
        output m_ack, m_err, m_rdata,
        input  f_ack, f_err, f_rdata, e_ack, e_err, e_rdata,
        input  m_req, m_addr, m_we, m_wdata, m_wstrb
    );
endinterface

// File: rtl/bus_watchdog.sv
// Transfer watchdog: counts enabled cycles since the last clear and flags
// expiry when the count reaches a non-zero limit.
module bus_watchdog (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);
    logic [7:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (enable && count_q != 8'hFF) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // A zero limit disables the watchdog entirely.
    assign expired = (limit != 8'd0) && (count_q == limit);

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the single memory bus between fetch and execute: execute has
// priority, fetch is forced after STARVE_LIMIT consecutive execute grants.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int         STARVE_LIMIT = 4,
    parameter logic [7:0] TIMEOUT      = 8'd255
) (
    input  logic                 clock,
    input  logic                 reset,
    bus_arbiter_if.master        bus,
    output logic                 owner,
    output logic                 busy
);
    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    logic [3:0]  streak_q, streak_d;
    logic        m_req_q, m_req_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wstrb_q, m_wstrb_d;

    logic grant, grant_exec, in_wait, done_err, done_ack, expired;

    bus_watchdog u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (grant),
        .enable  (in_wait),
        .limit   (TIMEOUT),
        .expired (expired)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        streak_d   = streak_q;
        m_req_d    = m_req_q;
        m_addr_d   = m_addr_q;
        m_we_d     = m_we_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        grant      = 1'b0;
        grant_exec = 1'b0;

        in_wait  = (state_q == ARB_WAIT);
        // An error beats a simultaneous ack; the watchdog counts as an error.
        done_err = in_wait && (bus.m_err || expired);
        done_ack = in_wait && bus.m_ack && !done_err;

        if (state_q == ARB_IDLE) begin
            grant      = bus.f_req || bus.e_req;
            grant_exec = bus.e_req && (!bus.f_req || streak_q != STREAK_MAX);
        end

        if (grant) begin
            state_d = ARB_WAIT;
            m_req_d = 1'b1;
            if (grant_exec) begin
                owner_d   = OWNER_EXECUTE;
                m_addr_d  = bus.e_addr;
                m_we_d    = bus.e_we;
                m_wdata_d = bus.e_wdata;
                m_wstrb_d = bus.e_wstrb;
                if (!bus.f_req) begin
                    streak_d = 4'd0;
                end else if (streak_q != STREAK_MAX) begin
                    streak_d = streak_q + 4'd1;
                end
            end else begin
                owner_d   = OWNER_FETCH;
                m_addr_d  = bus.f_addr;
                m_we_d    = 1'b0;
                m_wdata_d = 32'd0;
                m_wstrb_d = WSTRB_WORD;
                streak_d  = 4'd0;
            end
        end else if (done_err || done_ack) begin
            state_d = ARB_IDLE;
            m_req_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWNER_FETCH;
            streak_q  <= 4'd0;
            m_req_q   <= 1'b0;
            m_addr_q  <= 32'd0;
            m_we_q    <= 1'b0;
            m_wdata_q <= 32'd0;
            m_wstrb_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            streak_q  <= streak_d;
            m_req_q   <= m_req_d;
            m_addr_q  <= m_addr_d;
            m_we_q    <= m_we_d;
            m_wdata_q <= m_wdata_d;
            m_wstrb_q <= m_wstrb_d;
        end
    end

    // Completion pulses go to the owner only and are suppressed during reset.
    assign bus.f_ack   = !reset && done_ack && (owner_q == OWNER_FETCH);
    assign bus.f_err   = !reset && done_err && (owner_q == OWNER_FETCH);
    assign bus.e_ack   = !reset && done_ack && (owner_q == OWNER_EXECUTE);
    assign bus.e_err   = !reset && done_err && (owner_q == OWNER_EXECUTE);
    assign bus.f_rdata = bus.f_ack ? bus.m_rdata : 32'd0;
    assign bus.e_rdata = bus.e_ack ? bus.m_rdata : 32'd0;

    assign bus.m_req   = m_req_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wstrb = m_wstrb_q;

    assign owner = (owner_q == OWNER_EXECUTE);
    assign busy  = (state_q == ARB_WAIT);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: reset, fetch-only, priority, starvation,
// watchdog timeout, err-over-ack and reset during a transfer.
module tb_bus_arbiter;
    logic clock;
    logic reset;
    logic owner;
    logic busy;

    bus_arbiter_if bus ();

    bus_arbiter #(
        .STARVE_LIMIT (4),
        .TIMEOUT      (8'd8)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus),
        .owner (owner),
        .busy  (busy)
    );

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // ---------------- memory responder ----------------
    // mode 0: ack after mem_lat cycles; 1: never respond; 2: ack+err; 3: manual
    int          mem_mode = 3;
    int          mem_lat  = 2;
    logic [31:0] mem_rdata = 32'd0;
    logic        man_ack = 1'b0;
    logic        man_err = 1'b0;
    logic [31:0] man_rdata = 32'd0;
    int          mem_cnt = 0;
    bit          mem_done = 1'b0;

    always begin
        @(posedge clock);
        #2;
        if (mem_mode == 3) begin
            bus.m_ack   = man_ack;
            bus.m_err   = man_err;
            bus.m_rdata = man_rdata;
        end else begin
            bus.m_ack   = 1'b0;
            bus.m_err   = 1'b0;
            bus.m_rdata = 32'd0;
            if (bus.m_req === 1'b1 && !mem_done) begin
                if (mem_cnt == mem_lat && mem_mode != 1) begin
                    bus.m_ack   = 1'b1;
                    bus.m_err   = (mem_mode == 2);
                    bus.m_rdata = mem_rdata;
                    mem_done    = 1'b1;
                end
                mem_cnt++;
            end else if (bus.m_req !== 1'b1) begin
                mem_cnt  = 0;
                mem_done = 1'b0;
            end
        end
    end

    // ---------------- grant log and protocol monitor ----------------
    logic [0:0] grant_log[$];
    logic [0:0] exp_q[$];
    logic       m_req_prev = 1'b0;
    bit         proto_viol = 1'b0;

    always @(negedge clock) begin
        if (reset === 1'b0 && bus.m_req === 1'b1 && m_req_prev !== 1'b1)
            grant_log.push_back(owner);
        m_req_prev = bus.m_req;
        if (reset === 1'b0 && busy === 1'b1 && ((owner ? bus.e_req : bus.f_req) !== 1'b1))
            proto_viol = 1'b1;
    end

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1; mem_mode = 3; man_ack = 1'b1; man_err = 1'b1;
        bus.f_req = 1'b1; bus.f_addr = 32'h44; bus.e_req = 1'b1; bus.e_addr = 32'h88;
        bus.e_we = 1'b1; bus.e_wdata = 32'h1; bus.e_wstrb = 4'hF;
        tick; tick;
        @(negedge clock);
        total++;
        if ({bus.m_req, bus.m_we, owner, busy} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {bus.m_req, bus.m_we, owner, busy});
        end
        total++;
        if ({bus.f_ack, bus.f_err, bus.e_ack, bus.e_err} !== 4'b0) begin
            bad++; $display("FAIL reset_pulses got=%b want=0000", {bus.f_ack, bus.f_err, bus.e_ack, bus.e_err});
        end
        total++;
        if (bus.m_addr !== 32'd0 || bus.m_wdata !== 32'd0 || bus.m_wstrb !== 4'd0) begin
            bad++; $display("FAIL reset_bus addr=%h wdata=%h wstrb=%h want=0", bus.m_addr, bus.m_wdata, bus.m_wstrb);
        end
        bus.f_req = 1'b0; bus.e_req = 1'b0; man_ack = 1'b0; man_err = 1'b0;
        tick;
        reset = 1'b0; mem_mode = 0;
        tick;
        total++;
        if (busy !== 1'b0 || bus.m_req !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset busy=%b m_req=%b want=0", busy, bus.m_req);
        end
    endtask

    task automatic test_fetch_only;
        int ack_cnt = 0;
        int ack_idx = -1;
        mem_mode = 0; mem_lat = 2; mem_rdata = 32'hDEADBEEF;
        bus.f_addr = 32'h100; bus.f_req = 1'b1;
        tick;
        total++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h100 || bus.m_wstrb !== 4'hF || bus.m_we !== 1'b0 || owner !== 1'b0) begin
            bad++; $display("FAIL fetch_grant m_req=%b addr=%h wstrb=%h we=%b owner=%b want 1/100/f/0/0",
                            bus.m_req, bus.m_addr, bus.m_wstrb, bus.m_we, owner);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            total++;
            if (bus.e_ack !== 1'b0 || bus.e_err !== 1'b0 || bus.f_err !== 1'b0) begin
                bad++; $display("FAIL fetch_stray cyc=%0d e_ack=%b e_err=%b f_err=%b want 0", i, bus.e_ack, bus.e_err, bus.f_err);
            end
            if (bus.f_ack === 1'b1) begin
                ack_cnt++;
                if (ack_idx < 0) ack_idx = i;
                total++;
                if (bus.f_rdata !== 32'hDEADBEEF) begin
                    bad++; $display("FAIL fetch_rdata got=%h want=deadbeef", bus.f_rdata);
                end
                tick;
                bus.f_req = 1'b0;
            end else begin
                total++;
                if (bus.f_rdata !== 32'd0) begin
                    bad++; $display("FAIL fetch_rdata_idle cyc=%0d got=%h want=0", i, bus.f_rdata);
                end
            end
        end
        total++;
        if (ack_cnt != 1 || ack_idx != 2) begin
            bad++; $display("FAIL fetch_ack count=%0d cycle=%0d want count=1 cycle=2", ack_cnt, ack_idx);
        end
        tick;
    endtask

    task automatic test_simultaneous;
        mem_mode = 0; mem_lat = 2; mem_rdata = 32'hCAFEF00D;
        bus.e_addr = 32'h200; bus.e_we = 1'b1; bus.e_wdata = 32'h12345678; bus.e_wstrb = 4'hF;
        bus.f_addr = 32'h104;
        bus.e_req = 1'b1; bus.f_req = 1'b1;
        tick;
        total++;
        if (owner !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h200 || bus.m_wdata !== 32'h12345678 || bus.m_wstrb !== 4'hF) begin
            bad++; $display("FAIL both_exec_first owner=%b we=%b addr=%h wdata=%h wstrb=%h want 1/1/200/12345678/f",
                            owner, bus.m_we, bus.m_addr, bus.m_wdata, bus.m_wstrb);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            if (i == 2) begin
                total++;
                if (bus.e_ack !== 1'b1 || bus.f_ack !== 1'b0) begin
                    bad++; $display("FAIL both_e_ack e_ack=%b f_ack=%b want 1/0", bus.e_ack, bus.f_ack);
                end
                tick;
                bus.e_req = 1'b0;
            end else if (i == 3) begin
                total++;
                if (bus.m_req !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL both_idle_gap m_req=%b busy=%b want 0/0", bus.m_req, busy);
                end
            end else if (i == 4) begin
                total++;
                if (bus.m_req !== 1'b1 || owner !== 1'b0 || bus.m_addr !== 32'h104 || bus.m_we !== 1'b0 || bus.m_wstrb !== 4'hF) begin
                    bad++; $display("FAIL both_fetch_next m_req=%b owner=%b addr=%h we=%b wstrb=%h want 1/0/104/0/f",
                                    bus.m_req, owner, bus.m_addr, bus.m_we, bus.m_wstrb);
                end
            end else if (i == 6) begin
                total++;
                if (bus.f_ack !== 1'b1 || bus.f_rdata !== 32'hCAFEF00D || bus.e_ack !== 1'b0) begin
                    bad++; $display("FAIL both_f_ack f_ack=%b rdata=%h e_ack=%b want 1/cafef00d/0", bus.f_ack, bus.f_rdata, bus.e_ack);
                end
                tick;
                bus.f_req = 1'b0;
            end
        end
        tick;
    endtask

    task automatic test_starvation;
        int  e_cnt = 0;
        bit  f_done = 1'b0;
        bit  finished = 1'b0;
        mem_mode = 0; mem_lat = 1; mem_rdata = 32'h0BADF00D;
        grant_log.delete();
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.f_addr = 32'h180; bus.f_req = 1'b1;
        bus.e_addr = 32'h400; bus.e_we = 1'b0; bus.e_wdata = 32'd0; bus.e_wstrb = 4'hF; bus.e_req = 1'b1;
        for (int i = 0; i < 200 && !finished; i++) begin
            @(negedge clock);
            if (bus.e_ack === 1'b1) begin
                e_cnt++;
                if (e_cnt == 6) begin
                    tick;
                    bus.e_req = 1'b0;
                end
            end
            if (bus.f_ack === 1'b1) begin
                f_done = 1'b1;
                tick;
                bus.f_req = 1'b0;
            end
            finished = (e_cnt == 6) && f_done;
        end
        total++;
        if (!finished) begin
            bad++; $display("FAIL starve_budget e_acks=%0d f_done=%0d want 6/1", e_cnt, f_done);
        end
        total++;
        if (grant_log.size() != exp_q.size()) begin
            bad++; $display("FAIL starve_count got=%0d want=%0d", grant_log.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_q.size(); k++) begin
                total++;
                if (grant_log[k] !== exp_q[k]) begin
                    bad++; $display("FAIL starve_order idx=%0d got=%b want=%b", k, grant_log[k], exp_q[k]);
                end
            end
        end
        tick;
    endtask

    task automatic test_timeout;
        int err_cnt = 0;
        int err_idx = -1;
        mem_mode = 1;
        bus.e_addr = 32'h500; bus.e_we = 1'b0; bus.e_wstrb = 4'hF; bus.e_req = 1'b1;
        tick;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            total++;
            if (bus.e_ack !== 1'b0 || bus.f_ack !== 1'b0 || bus.f_err !== 1'b0) begin
                bad++; $display("FAIL timeout_stray cyc=%0d e_ack=%b f_ack=%b f_err=%b want 0", i, bus.e_ack, bus.f_ack, bus.f_err);
            end
            if (i == 9) begin
                total++;
                if (bus.m_req !== 1'b0 || busy !== 1'b0) begin
                    bad++; $display("FAIL timeout_release m_req=%b busy=%b want 0/0", bus.m_req, busy);
                end
            end
            if (bus.e_err === 1'b1) begin
                err_cnt++;
                if (err_idx < 0) err_idx = i;
                tick;
                bus.e_req = 1'b0;
            end
        end
        total++;
        if (err_cnt != 1 || err_idx != 8) begin
            bad++; $display("FAIL timeout_err count=%0d cycle=%0d want count=1 cycle=8", err_cnt, err_idx);
        end
        mem_mode = 0;
        tick;
    endtask

    task automatic test_err_and_ack;
        mem_mode = 2; mem_lat = 2; mem_rdata = 32'h11112222;
        bus.f_addr = 32'h140; bus.f_req = 1'b1;
        tick;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (i == 2) begin
                total++;
                if (bus.f_err !== 1'b1 || bus.f_ack !== 1'b0 || bus.f_rdata !== 32'd0 || bus.e_err !== 1'b0) begin
                    bad++; $display("FAIL err_wins f_err=%b f_ack=%b rdata=%h e_err=%b want 1/0/0/0",
                                    bus.f_err, bus.f_ack, bus.f_rdata, bus.e_err);
                end
                tick;
                bus.f_req = 1'b0;
            end else if (i == 3) begin
                total++;
                if (busy !== 1'b0 || bus.m_req !== 1'b0) begin
                    bad++; $display("FAIL err_idle busy=%b m_req=%b want 0/0", busy, bus.m_req);
                end
            end
        end
        mem_mode = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        mem_mode = 3; man_ack = 1'b0; man_err = 1'b0;
        bus.e_addr = 32'h600; bus.e_we = 1'b1; bus.e_wdata = 32'hA5A5A5A5; bus.e_wstrb = 4'h3; bus.e_req = 1'b1;
        tick;
        total++;
        if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_wstrb !== 4'h3 || bus.m_wdata !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL rmid_grant m_req=%b we=%b wstrb=%h wdata=%h want 1/1/3/a5a5a5a5",
                            bus.m_req, bus.m_we, bus.m_wstrb, bus.m_wdata);
        end
        for (int i = 0; i < 7; i++) begin
            if (i == 1) reset = 1'b1;
            if (i == 2) begin
                total++;
                if (bus.m_req !== 1'b0 || busy !== 1'b0 || bus.m_addr !== 32'd0) begin
                    bad++; $display("FAIL rmid_abort m_req=%b busy=%b addr=%h want 0/0/0", bus.m_req, busy, bus.m_addr);
                end
                reset = 1'b0; bus.e_req = 1'b0;
                man_ack = 1'b1; man_rdata = 32'h77778888;
            end
            if (i == 3) man_ack = 1'b0;
            @(negedge clock);
            pulses += int'(bus.e_ack === 1'b1) + int'(bus.e_err === 1'b1) + int'(bus.f_ack === 1'b1) + int'(bus.f_err === 1'b1);
            if (i >= 2) begin
                total++;
                if (busy !== 1'b0 || bus.e_rdata !== 32'd0) begin
                    bad++; $display("FAIL rmid_late_ack cyc=%0d busy=%b e_rdata=%h want 0/0", i, busy, bus.e_rdata);
                end
            end
            tick;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("FAIL rmid_pulses got=%0d want=0", pulses);
        end
        mem_mode = 0;
    endtask

    task automatic test_protocol;
        total++;
        if (proto_viol !== 1'b0) begin
            bad++; $display("FAIL req_held got=%b want=0", proto_viol);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.f_req = 1'b0; bus.f_addr = 32'd0;
        bus.e_req = 1'b0; bus.e_addr = 32'd0; bus.e_we = 1'b0; bus.e_wdata = 32'd0; bus.e_wstrb = 4'd0;
        bus.m_ack = 1'b0; bus.m_err = 1'b0; bus.m_rdata = 32'd0;
        test_reset;
        test_fetch_only;
        test_simultaneous;
        test_starvation;
        test_timeout;
        test_err_and_ack;
        test_reset_mid;
        test_protocol;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single memory bus master between the fetch path (read-only) and the execute unit's load/store path.
- Sits between the front/back ends and the bus: it picks one requester, drives the bus with registered signals, holds the grant until the memory acks, and routes the ack, read data and error back to the winner.
- Provides execute-priority arbitration with an anti-starvation limit for fetch, plus a watchdog timeout.

Parameters:
- STARVE_LIMIT, 4: consecutive execute grants allowed while fetch is pending; the next grant is forced to fetch. Range 1..15.
- TIMEOUT, 255: cycles to wait for m_ack before aborting with an error; 0 disables the watchdog. Width 8 bits.

Ports:
- clock  in  1  single clock; all logic is posedge.
- reset  in  1  synchronous, active-high reset.
- f_req  in  1  fetch request; held with a stable f_addr until f_ack or f_err.
- f_addr  in  32  fetch word address.
- f_ack  out  1  one-cycle pulse: fetch transfer done.
- f_err  out  1  one-cycle pulse: fetch aborted by timeout or m_err.
- f_rdata  out  32  fetch read data; valid only with f_ack.
- e_req  in  1  execute request; held with stable e_* fields until e_ack or e_err.
- e_addr  in  32  load/store address.
- e_we  in  1  1 = store, 0 = load.
- e_wdata  in  32  store data.
- e_wstrb  in  4  byte enables (SB/SH/SW).
- e_ack  out  1  one-cycle pulse: execute transfer done.
- e_err  out  1  one-cycle pulse: execute transfer aborted.
- e_rdata  out  32  load data; valid only with e_ack.
- m_req  out  1  bus request, registered.
- m_addr  out  32  bus address, registered.
- m_we  out  1  bus write enable, registered.
- m_wdata  out  32  bus write data, registered.
- m_wstrb  out  4  bus byte strobes, registered; 4'hF for fetch.
- m_ack  in  1  memory completion, single cycle.
- m_err  in  1  memory error, single cycle.
- m_rdata  in  32  memory read data, valid with m_ack.
- owner  out  1  current or last grant: 0 = fetch, 1 = execute.
- busy  out  1  1 while the state is not IDLE.

Behaviour:
- Reset (sync, high) applies at the clock edge. It forces:
  - state IDLE;
  - m_req, m_we = 0; m_addr, m_wdata = 0; m_wstrb = 0;
  - owner = 0; busy = 0;
  - streak counter and watchdog counter = 0.
  - All ack/err outputs read 0 while reset is high.
- Reset mid-transaction abandons the transfer with no ack/err to either requester. A late m_ack after reset is ignored.
- States:
  - IDLE:
    - if neither request is present, stay in IDLE;
    - if only one request is present, grant it;
    - if both are present, grant execute unless streak == STARVE_LIMIT, in which case grant fetch.
  - On grant, at the same edge:
    - load m_* from the winner and set m_req = 1;
    - set owner;
    - go to WAIT.
  - WAIT:
    - m_* are held constant and the watchdog increments each cycle.
    - On m_ack: combinationally pulse the owner's ack and drive rdata = m_rdata in that same cycle. Next edge: m_req = 0, go to IDLE.
    - On m_err, or watchdog == TIMEOUT (when TIMEOUT != 0): pulse the owner's err for one cycle. Next edge: m_req = 0, go to IDLE.
- m_ack and m_err in the same cycle: err wins; no ack is issued.
- Latency:
  - request seen in IDLE at edge N → m_req high after edge N;
  - owner ack in the m_ack cycle;
  - earliest re-grant is the edge after returning to IDLE, so there is minimum one idle bus cycle between transfers.
- Streak counter:
  - increments on each execute grant while f_req is high;
  - clears on any fetch grant, and on an execute grant while f_req is low;
  - saturates at STARVE_LIMIT.
- The watchdog clears on every grant.
- A requester deasserting req during WAIT is a protocol violation: the transfer still completes and the ack is still pulsed. The bench asserts the violation never happens.
- The non-owner's ack and err are always 0. rdata outputs are 0 when not acked.
- m_m_rdata passes through to the owner only; there is no read-data register.

Decomposition:
- Shared package (bus_pkg) holds:
  - typedef enum arb_state {ARB_IDLE, ARB_WAIT};
  - typedef enum owner_t {OWNER_FETCH, OWNER_EXECUTE};
  - constant WSTRB_WORD = 4'hF.
- One natural sub-module, bus_watchdog:
  - 8-bit counter with inputs clear, enable, limit;
  - output expired, asserted when the count reaches limit and limit != 0.

Test Plan:
- Fetch only: f_req = 1, f_addr = 0x100; memory acks 2 cycles after m_req with rdata 0xDEADBEEF → m_addr = 0x100, m_wstrb = 4'hF, m_we = 0; f_ack pulses once with f_rdata = 0xDEADBEEF; e_ack stays 0.
- Simultaneous requests: f_req and e_req (SW of 0x12345678 to 0x200, wstrb 4'hF) both raised in the same cycle → execute is granted first with m_we = 1; fetch is granted after e_ack plus one idle cycle.
- Starvation: f_req held high while e_req issues 6 back-to-back loads, STARVE_LIMIT = 4 → grant order is E, E, E, E, F, E, E.
- Timeout: TIMEOUT = 8, e_req load, memory never acks → e_err pulses exactly 8 cycles after m_req rises; m_req drops the next cycle; state returns to IDLE.
- m_err plus m_ack together on a fetch → f_err = 1, f_ack = 0, busy = 0 the following cycle.
- Reset mid-WAIT: reset asserted 2 cycles into an execute store → after that edge m_req = 0 and busy = 0; neither e_ack nor e_err ever pulses; a later m_ack is ignored.
